// File: rtl/wb_single_master_if.sv
// Request/response and Wishbone signals of the single-transfer initiator.
// The master modport is the initiator side and the slave modport is the client/peripheral side.
interface wb_single_master_if;
  logic        i_req;
  logic        i_req_we;
  logic [31:0] i_req_adr;
  logic [31:0] i_req_data;
  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_data;
  logic [31:0] i_wb_data;
  logic        i_wb_ack;

  modport master (
    input  i_req, i_req_we, i_req_adr, i_req_data, i_wb_data, i_wb_ack,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
           o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data
  );

  modport slave (
    output i_req, i_req_we, i_req_adr, i_req_data, i_wb_data, i_wb_ack,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
           o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data
  );
endinterface

// File: rtl/wb_single_master.sv
// Wishbone classic single-transfer initiator with a bounded wait per transfer.
// Optional macro WBM_RETRY_EN: retry a timed-out transfer up to MAX_RETRY extra times.
module wb_single_master #(
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 2
) (
  input logic                i_wb_clk,
  input logic                i_wb_rst_n,
  wb_single_master_if.master bus
);

`ifdef WBM_RETRY_EN
  typedef enum logic [1:0] {IDLE, BUS, RESP, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
`endif

  state_t      r_state;
  state_t      w_stateNext;
  logic [7:0]  r_waitCnt;
  logic        r_wbWe;
  logic [31:0] r_wbAdr;
  logic [31:0] r_wbData;
  logic [31:0] r_rspData;
  logic        r_rspErr;
  logic        w_accept;
  logic        w_ackDone;
  logic        w_timeout;
  logic        w_waitLast;
`ifdef WBM_RETRY_EN
  logic [1:0]  r_retryCnt;
  logic        w_retry;
`endif

  assign w_waitLast = (r_waitCnt == 8'(TIMEOUT - 1));

  // Control outputs are decoded straight from the state register so reset drops cyc/stb at once.
  assign bus.o_req_ready = (r_state == IDLE);
  assign bus.o_rsp_valid = (r_state == RESP);
  assign bus.o_wb_cyc    = (r_state == BUS);
  assign bus.o_wb_stb    = (r_state == BUS);
  assign bus.o_wb_we     = r_wbWe;
  assign bus.o_wb_adr    = r_wbAdr;
  assign bus.o_wb_data   = r_wbData;
  assign bus.o_rsp_data  = r_rspData;
  assign bus.o_rsp_err   = r_rspErr;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) r_state <= IDLE;
    else             r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_ackDone   = 1'b0;
    w_timeout   = 1'b0;
`ifdef WBM_RETRY_EN
    w_retry     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (bus.i_req) begin
          w_accept    = 1'b1;
          w_stateNext = BUS;
        end
      end
      BUS: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (bus.i_wb_ack) begin
          w_ackDone   = 1'b1;
          w_stateNext = RESP;
        end else if (w_waitLast) begin
`ifdef WBM_RETRY_EN
          if (r_retryCnt < 2'(MAX_RETRY)) begin
            w_retry     = 1'b1;
            w_stateNext = GAP;
          end else
`endif
          begin
            w_timeout   = 1'b1;
            w_stateNext = RESP;
          end
        end
      end
      RESP: w_stateNext = IDLE;
`ifdef WBM_RETRY_EN
      GAP:  w_stateNext = BUS;
`endif
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_wbWe    <= 1'b0;
      r_wbAdr   <= '0;
      r_wbData  <= '0;
      r_waitCnt <= '0;
      r_rspData <= '0;
      r_rspErr  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wbWe   <= bus.i_req_we;
        r_wbAdr  <= bus.i_req_adr;
        r_wbData <= bus.i_req_data;
      end
`ifdef WBM_RETRY_EN
      if (w_accept || w_retry) r_waitCnt <= '0;
`else
      if (w_accept) r_waitCnt <= '0;
`endif
      else if (r_state == BUS) r_waitCnt <= r_waitCnt + 8'd1;
      // Response fields hold until the next transfer finishes.
      if (w_ackDone) begin
        r_rspData <= r_wbWe ? 32'd0 : bus.i_wb_data;
        r_rspErr  <= 1'b0;
      end else if (w_timeout) begin
        r_rspData <= 32'd0;
        r_rspErr  <= 1'b1;
      end
    end
  end

`ifdef WBM_RETRY_EN
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n)  r_retryCnt <= '0;
    else if (w_accept) r_retryCnt <= '0;
    else if (w_retry)  r_retryCnt <= r_retryCnt + 2'd1;
  end
`endif

endmodule

// File: tb/tb_wb_single_master.sv
// Self-checking bench for wb_single_master: directed and randomized transfers against a
// transfer-level model of cycle counts, response data and error flag.
module tb_wb_single_master;
  localparam int TIMEOUT   = 16;
  localparam int MAX_RETRY = 2;
  localparam int NEVER     = 1000;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   slaveDelay = NEVER;
  int   slaveCnt;
  logic spuriousAck = 1'b0;

  wb_single_master_if bus ();

  wb_single_master #(
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_wb_clk  (clk),
    .i_wb_rst_n(rst_n),
    .bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slave: acks on stb cycle slaveDelay+1 of each attempt, combinationally from stb.
  always @(posedge clk) begin
    if (bus.o_wb_stb) slaveCnt <= slaveCnt + 1;
    else              slaveCnt <= 0;
  end
  assign bus.i_wb_ack = (bus.o_wb_stb && (slaveCnt == slaveDelay)) || spuriousAck;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request from a negedge in IDLE and returns at the negedge after the response.
  task automatic applyStimulus(input string name, input logic we, input logic [31:0] adr,
                               input logic [31:0] data, input logic [31:0] rdata, input int delay);
    int attempts, expStb, expRsp, stbCycles, rspCycle;
    logic expErr, stableOk;
    logic [31:0] expData;
`ifdef WBM_RETRY_EN
    attempts = MAX_RETRY + 1;
`else
    attempts = 1;
`endif
    if (delay < TIMEOUT) begin
      expErr = 1'b0; expStb = delay + 1; expRsp = delay + 2; expData = we ? 32'd0 : rdata;
    end else begin
      expErr = 1'b1; expStb = TIMEOUT * attempts; expRsp = expStb + attempts; expData = 32'd0;
    end
    checkOutput({name, ".readyBefore"}, {31'd0, bus.o_req_ready}, 32'd1);
    slaveDelay     = delay;
    bus.i_wb_data  = rdata;
    bus.i_req      = 1'b1;
    bus.i_req_we   = we;
    bus.i_req_adr  = adr;
    bus.i_req_data = data;
    @(negedge clk);
    bus.i_req      = 1'b0;
    bus.i_req_we   = ~we;
    bus.i_req_adr  = $urandom;
    bus.i_req_data = $urandom;
    stbCycles = 0; rspCycle = 0; stableOk = 1'b1;
    for (int k = 1; k <= 300 && rspCycle == 0; k++) begin
      if (bus.o_wb_cyc !== bus.o_wb_stb) stableOk = 1'b0;
      if (bus.o_wb_stb === 1'b1) begin
        stbCycles++;
        if (bus.o_wb_adr !== adr || bus.o_wb_we !== we || bus.o_wb_data !== data) stableOk = 1'b0;
      end
      if (bus.o_rsp_valid === 1'b1) rspCycle = k;
      else @(negedge clk);
    end
    checkOutput({name, ".rspCycle"}, rspCycle, expRsp);
    checkOutput({name, ".stbCycles"}, stbCycles, expStb);
    checkOutput({name, ".stable"}, {31'd0, stableOk}, 32'd1);
    checkOutput({name, ".rspErr"}, {31'd0, bus.o_rsp_err}, {31'd0, expErr});
    checkOutput({name, ".rspData"}, bus.o_rsp_data, expData);
    @(negedge clk);
    checkOutput({name, ".pulseEnd"}, {31'd0, bus.o_rsp_valid}, 32'd0);
    checkOutput({name, ".readyAfter"}, {31'd0, bus.o_req_ready}, 32'd1);
    checkOutput({name, ".holdData"}, bus.o_rsp_data, expData);
    checkOutput({name, ".holdErr"}, {31'd0, bus.o_rsp_err}, {31'd0, expErr});
    slaveDelay = NEVER;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] acceptMask;
    logic        flagOk;
    int          pulses;
    logic [31:0] expAdr[$];

    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_req_we = 1'b0; bus.i_req_adr = '0; bus.i_req_data = '0;
    bus.i_wb_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset.ready", {31'd0, bus.o_req_ready}, 32'd1);
    checkOutput("reset.cyc", {31'd0, bus.o_wb_cyc}, 32'd0);
    checkOutput("reset.stb", {31'd0, bus.o_wb_stb}, 32'd0);
    checkOutput("reset.rspValid", {31'd0, bus.o_rsp_valid}, 32'd0);
    checkOutput("reset.adr", bus.o_wb_adr, 32'd0);
    checkOutput("reset.rspData", bus.o_rsp_data, 32'd0);
    checkOutput("reset.rspErr", {31'd0, bus.o_rsp_err}, 32'd0);

    $display("[TB] directed transfers");
    applyStimulus("zeroWaitWrite", 1'b1, 32'h0000_0010, 32'h0000_01F4, 32'hDEAD_BEEF, 0);
    applyStimulus("read3Wait", 1'b0, 32'h0000_0014, 32'h1234_5678, 32'h0000_0ABC, 3);
    applyStimulus("timeout", 1'b0, 32'h0000_0020, 32'h0, 32'h5555_AAAA, NEVER);
    applyStimulus("ackLastCycle", 1'b0, 32'h0000_0024, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1);
    applyStimulus("timeoutWrite", 1'b1, 32'h0000_0028, 32'h0000_0077, 32'h0, NEVER);

    $display("[TB] spurious ack in IDLE");
    spuriousAck = 1'b1;
    flagOk = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0 || bus.o_wb_cyc !== 1'b0) flagOk = 1'b0;
    end
    spuriousAck = 1'b0;
    checkOutput("spurious.idle", {31'd0, flagOk}, 32'd1);
    checkOutput("spurious.rspErr", {31'd0, bus.o_rsp_err}, 32'd1);

    $display("[TB] back-to-back requests");
    slaveDelay = 0;
    acceptMask = '0; pulses = 0; flagOk = 1'b1;
    bus.i_req = 1'b1; bus.i_req_we = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (bus.o_rsp_valid === 1'b1) begin
        pulses++;
        if (expAdr.size() > 0) void'(expAdr.pop_front());
      end
      if (bus.o_wb_stb === 1'b1) begin
        if (expAdr.size() == 0) flagOk = 1'b0;
        else if (bus.o_wb_adr !== expAdr[0]) flagOk = 1'b0;
      end
      if (k < 10) begin
        bus.i_req_adr = $urandom;
        bus.i_wb_data = $urandom;
        if (bus.o_req_ready === 1'b1) begin
          acceptMask[k] = 1'b1;
          expAdr.push_back(bus.i_req_adr);
        end
      end else bus.i_req = 1'b0;
      @(negedge clk);
    end
    slaveDelay = NEVER;
    checkOutput("b2b.acceptCycles", {16'd0, acceptMask}, 32'h0000_0249);
    checkOutput("b2b.responses", pulses, 32'd4);
    checkOutput("b2b.adrFollow", {31'd0, flagOk}, 32'd1);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 12; n++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT - 1));
      applyStimulus("random", 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, d);
    end

    $display("[TB] reset mid-transfer");
    slaveDelay = NEVER;
    bus.i_req = 1'b1; bus.i_req_we = 1'b0; bus.i_req_adr = 32'h0000_0030;
    @(negedge clk);
    bus.i_req = 1'b0;
    @(negedge clk);
    checkOutput("midReset.stbBefore", {31'd0, bus.o_wb_stb}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.cyc", {31'd0, bus.o_wb_cyc}, 32'd0);
    checkOutput("midReset.stb", {31'd0, bus.o_wb_stb}, 32'd0);
    checkOutput("midReset.ready", {31'd0, bus.o_req_ready}, 32'd1);
    flagOk = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.o_rsp_valid !== 1'b0) flagOk = 1'b0;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_rsp_valid !== 1'b0 || bus.o_req_ready !== 1'b1) flagOk = 1'b0;
    end
    checkOutput("midReset.noResponse", {31'd0, flagOk}, 32'd1);
    checkOutput("midReset.rspErr", {31'd0, bus.o_rsp_err}, 32'd0);
    applyStimulus("afterReset", 1'b0, 32'h0000_0034, 32'h0, 32'h0BAD_F00D, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_single_master.md
Name: wb_single_master

Overview:
Wishbone classic single-transfer initiator. It drives the peripheral slaves (PWM/LED/LCD/ADC/buzzer register block) from a local request/response interface. Typical clients are the control sequencer or debug port, which need to read or write one 32-bit register at a time. Each transfer has a bounded wait: a slave that never acks ends the cycle with an error response.

Parameters:
TIMEOUT, 16, max cycles with cyc/stb asserted and no ack before abort (legal range 1..255).
MAX_RETRY, 2, extra attempts after a timeout; used only when WBM_RETRY_EN is defined.

Ports:
i_wb_clk  input  1  bus clock; all logic is on its rising edge.
i_wb_rst_n  input  1  asynchronous, active-low reset.
i_req  input  1  request strobe from the local client.
i_req_we  input  1  1 = write, 0 = read.
i_req_adr  input  32  target address.
i_req_data  input  32  write data.
o_req_ready  output  1  block can accept a request this cycle.
o_rsp_valid  output  1  one-cycle pulse marking transfer completion.
o_rsp_data  output  32  read data (0 for writes and errors).
o_rsp_err  output  1  transfer timed out; valid with o_rsp_valid.
o_wb_cyc  output  1  Wishbone cycle.
o_wb_stb  output  1  Wishbone strobe.
o_wb_we  output  1  Wishbone write enable.
o_wb_adr  output  32  Wishbone address.
o_wb_data  output  32  Wishbone write data.
i_wb_data  input  32  Wishbone read data.
i_wb_ack  input  1  Wishbone acknowledge; may be combinational from stb (zero wait states).

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0 except o_req_ready. o_req_ready is 1 because it is decoded from IDLE.
- Reset mid-transfer: o_wb_cyc/o_wb_stb drop immediately (asynchronously), and no response is issued.
- FSM states: IDLE, BUS, RESP.
- IDLE: o_req_ready = 1.
  - On i_req=1, latch we/adr/data into o_wb_we/o_wb_adr/o_wb_data.
  - Set cyc=stb=1, clear the wait counter, go to BUS.
- BUS:
  - cyc and stb are held high.
  - adr/we/data are held stable for the whole cycle.
  - i_req is ignored (o_req_ready = 0).
- BUS, i_wb_ack=1 at a clock edge:
  - Capture i_wb_data into o_rsp_data if it is a read, else 0.
  - Clear o_rsp_err, drop cyc/stb, go to RESP.
- BUS, no ack: the 8-bit wait counter increments. When the counter reaches TIMEOUT-1 with still no ack:
  - Drop cyc/stb.
  - Set o_rsp_data=0 and o_rsp_err=1.
  - Go to RESP.
- Ack in the same cycle the counter reaches its limit: the ack wins and the transfer completes normally.
- RESP: o_rsp_valid=1 for exactly one cycle, then IDLE.
- o_rsp_data and o_rsp_err hold their value until the next response.
- Latency with a zero-wait slave:
  - Request accepted at edge 0.
  - stb high in cycle 1; ack sampled at edge 1.
  - o_rsp_valid high in cycle 2.
  - o_req_ready high again in cycle 3.
- Throughput: 1 transfer per 3 cycles minimum.
- An ack while in IDLE or RESP (spurious) is ignored.
- o_wb_cyc always equals o_wb_stb; there are no block transfers.

Optional Feature:
WBM_RETRY_EN
- Defined:
  - On timeout, the FSM returns to BUS with the same adr/we/data and a cleared wait counter.
  - It inserts one idle cycle with cyc=stb=0 between attempts.
  - It retries up to MAX_RETRY times; err is reported only after the final attempt times out.
  - A 2-bit retry counter resets on each new request.
- Undefined: the first timeout reports err; MAX_RETRY is unused.

Test Plan:
- Zero-wait write: req we=1 adr=0x0000_0010 data=0x0000_01F4, ack=stb -> one stb cycle carrying those values; rsp_valid in cycle 2, err=0, rsp_data=0.
- Read with 3 wait states: req we=0 adr=0x0000_0014, slave acks on the 4th stb cycle with data 0x0000_0ABC -> rsp_data=0x0000_0ABC, err=0; adr stable for all 4 cycles.
- Timeout (TIMEOUT=16, no ack) -> stb high exactly 16 cycles, then rsp_valid with err=1, rsp_data=0. With WBM_RETRY_EN and MAX_RETRY=2: 3 attempts, 48 stb cycles total, then err=1.
- Reset mid-transfer: assert i_wb_rst_n=0 in the 2nd wait cycle -> cyc/stb low before the next edge, no rsp_valid, ready=1 after release.
- Back-to-back: hold i_req=1 for 10 cycles with zero-wait ack -> exactly 4 transfers (accepted at cycles 0, 3, 6, 9); requests are ignored while ready=0.
- Ack on the last allowed cycle (ack at stb cycle 16, TIMEOUT=16) -> normal completion, err=0.
